// File: rtl/noc_axi4_bridge_resp_arb.sv
`default_nettype none
// ============================================================================
// Module   : noc_axi4_bridge_resp_arb
// Brief    : Read/write response arbiter with a one-entry registered output
//            stage feeding the NoC response serializer. Reads have priority;
//            a burst limit guarantees write forward progress.
// Revision : 1.0 - initial release
// ============================================================================
module noc_axi4_bridge_resp_arb #(
    parameter int MAX_BURST        = 4,
    parameter int MSG_HEADER_WIDTH = 192,
    parameter int AXI4_DATA_WIDTH  = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MSG_HEADER_WIDTH-1:0] rd_header_in,
    input  logic [AXI4_DATA_WIDTH-1:0]  rd_data_in,
    input  logic                        rd_val,
    output logic                        rd_rdy,
    input  logic [MSG_HEADER_WIDTH-1:0] wr_header_in,
    input  logic                        wr_val,
    output logic                        wr_rdy,
    output logic [MSG_HEADER_WIDTH-1:0] ser_header,
    output logic [AXI4_DATA_WIDTH-1:0]  ser_data,
    output logic                        ser_val,
    input  logic                        ser_rdy
);

    localparam logic [3:0] c_max_burst = MAX_BURST[3:0];

    logic                        r_ser_val;
    logic                        r_out_src;    // 0 = read entry, 1 = write entry
    logic [3:0]                  r_burst_cnt;
    logic [MSG_HEADER_WIDTH-1:0] r_header;
    logic [AXI4_DATA_WIDTH-1:0]  r_rd_data;

    logic w_load_en;
    logic w_at_limit;
    logic w_grant_rd;
    logic w_grant_wr;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_load_en  = ~r_ser_val | ser_rdy;
    assign w_at_limit = (r_burst_cnt >= c_max_burst);
    assign w_grant_rd = rd_val & (~wr_val | ~w_at_limit);
    assign w_grant_wr = wr_val & (~rd_val |  w_at_limit);

    // Grants only exist in the accept cycle, so no lock state is needed.
    assign w_rd_acc = ~rst & w_load_en & w_grant_rd;
    assign w_wr_acc = ~rst & w_load_en & w_grant_wr;

    assign rd_rdy = w_rd_acc;
    assign wr_rdy = w_wr_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ser_val   <= 1'b0;
            r_out_src   <= 1'b0;
            r_burst_cnt <= 4'd0;
        end else begin
            if (w_load_en) begin
                r_ser_val <= w_rd_acc | w_wr_acc;
            end
            if (w_wr_acc) begin
                r_out_src   <= 1'b1;
                r_burst_cnt <= 4'd0;
            end else if (w_rd_acc) begin
                r_out_src <= 1'b0;
                if (wr_val) begin
                    r_burst_cnt <= r_burst_cnt + 4'd1;
                end
            end
        end
    end

    // Payload is don't-care while ser_val is low, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_header <= wr_header_in;
        end else if (w_rd_acc) begin
            r_header  <= rd_header_in;
            r_rd_data <= rd_data_in;
        end
    end

    // Write entries carry no data; zeroing at the output avoids a wide load mux.
    assign ser_header = r_header;
    assign ser_data   = r_out_src ? '0 : r_rd_data;
    assign ser_val    = r_ser_val;

endmodule
`default_nettype wire

// File: doc/noc_axi4_bridge_resp_arb.md
# noc_axi4_bridge_resp_arb

Two-source response arbiter placed in front of the NoC response serializer in the AXI4 bridge. It shares the serializer's single header/data input between the read-response path (load and NC-load acks with 512-bit data) and the write-response path (store and NC-store acks, header only). It provides a one-entry registered output stage, which decouples request timing from the serializer. Reads have priority, and a burst limit guarantees write forward progress.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum consecutive read grants while a write is pending. Legal range 1..15.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `rd_header_in` input `MSG_HEADER_WIDTH`: read-response request header.
- `rd_data_in` input `AXI4_DATA_WIDTH`: read data.
- `rd_val` input 1: read request valid.
- `rd_rdy` output 1: read request accepted this cycle when `rd_val` is also high.
- `wr_header_in` input `MSG_HEADER_WIDTH`: write-response request header.
- `wr_val` input 1: write request valid.
- `wr_rdy` output 1: write accept.
- `ser_header` output `MSG_HEADER_WIDTH`: to serializer `header_in`.
- `ser_data` output `AXI4_DATA_WIDTH`: to serializer `data_in`.
- `ser_val` output 1: to serializer `in_val`.
- `ser_rdy` input 1: from serializer `in_rdy`.

## Operation
- **Output register.** Holds `ser_header`, `ser_data`, `ser_val` and `out_src` (0 = read, 1 = write).
- **Load enable.** `load_en = ~ser_val | ser_rdy`.
  - The register reloads only when `load_en` is high and a grant is issued.
  - When `load_en` is high with no grant, `ser_val` goes 0 on the next edge.
- **Grant logic (combinational, evaluated only when `load_en` = 1).**
  - Only `rd_val` high: grant read.
  - Only `wr_val` high: grant write.
  - Both high:
    - `burst_cnt < MAX_BURST`: grant read.
    - `burst_cnt == MAX_BURST`: grant write.
- **Ready outputs.**
  - `rd_rdy = load_en & grant_rd`
  - `wr_rdy = load_en & grant_wr`
  - Never both high in the same cycle.
  - Neither depends on `ser_val` of the same source beyond `load_en`.
- **Load contents.**
  - On a write grant, `ser_data` loads all zeros.
  - On a read grant, `ser_data` loads `rd_data_in`.
  - `ser_header` loads the granted header unchanged. Header translation is the serializer's job.
- **`burst_cnt`**, width 4:
  - Cleared on a write grant.
  - Incremented on a read grant taken while `wr_val` = 1.
  - Held otherwise.
  - Never exceeds `MAX_BURST`.
- **Handshake rules.**
  - Requesters must hold `val` and payload stable until their `rdy` is seen.
  - The arbiter may switch grant between cycles while a requester waits. There is no lock, because grant exists only in the accept cycle.
- **Reset.**
  - Clears `ser_val`, `out_src` and `burst_cnt`.
  - Forces `rd_rdy` = `wr_rdy` = 0 while `rst` is high.
  - `ser_header` and `ser_data` are not reset (don't care while `ser_val` = 0).
  - Reset mid-transfer drops the registered entry. No beat is replayed.

## Timing
- **Latency.** A request accepted at edge N appears with `ser_val` = 1 from edge N+1.
- **Throughput.** Back-to-back: with `ser_rdy` = 1 continuously, one grant per cycle.
- **Stall.** `ser_val` = 1 with `ser_rdy` = 0 holds all output fields stable and deasserts both `rdy` outputs.
- **Simultaneous events.**
  - `ser_rdy` = 1 in the same cycle a new grant is made: the old entry is consumed and the new one loaded on the same edge. No bubble.
  - `rd_val` and `wr_val` rising together with `burst_cnt` = 0: read wins.
- **Saturation.** After `MAX_BURST` read grants with write continuously pending, the next grant is write.

## Test plan
- **Reset.** Assert `rst` 2 cycles with `rd_val` = `wr_val` = 1 → `ser_val` = 0, `rd_rdy` = `wr_rdy` = 0. The first cycle after deassert grants read, and `ser_val` = 1 one cycle later.
- **Single read.** `rd_val` 1 cycle, header type LOAD_MEM, data = 512'hA5…A5, `ser_rdy` = 1 → `ser_header`/`ser_data` match exactly at N+1, `ser_val` for 1 cycle.
- **Starvation limit.** `MAX_BURST` = 4, `rd_val` and `wr_val` held high, `ser_rdy` = 1 → grant order R,R,R,R,W,R,R,R,R,W; `burst_cnt` peaks at 4.
- **Backpressure.** `ser_val` = 1, `ser_rdy` = 0 for 5 cycles with both requesters valid → outputs stable, no `rdy` asserted. On `ser_rdy` = 1, next grant is loaded the same edge.
- **Write data.** Single write with `wr_header_in` type NC_STORE_REQ → `ser_data` = 0 and header passed through unchanged.
- **Mid-transfer reset.** Reset asserted while `ser_val` = 1 and stalled → `ser_val` = 0 next cycle, `burst_cnt` = 0, and the next both-valid grant is read.
